// File: rtl/seq_divider16_pkg.sv
// Shared definitions for the sequential restoring divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_divider16_pkg;

  // Divider FSM encoding; value 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 16;

  // Width of the iteration counter: must hold the value WIDTH itself.
  function automatic int div_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_divider16_div_step.sv
// One combinational restoring-division iteration (shift in next dividend bit, trial subtract).
// Latency: combinational.
// Backpressure: none.
// Ports: rem (partial remainder), q_msb (next dividend bit), dvsr (divisor)
//        -> rem_next (updated partial remainder), q_bit (quotient bit produced).
module div_step
  import seq_divider16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem, q_msb};
  assign trial   = shifted - {1'b0, dvsr};

  // The partial remainder is always below the divisor, so both the kept
  // difference and the restored value fit in WIDTH bits; trial's MSB is the borrow.
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/seq_divider16.sv
// Multi-cycle unsigned restoring divider with valid/ready input and output handshakes.
// Latency: WIDTH+1 edges from accept to out_valid (1 edge for a zero divisor).
// Backpressure: result held in DONE until out_ready; no new input accepted until back in IDLE.
// Ports: clk, rst (async active-high); in_valid/in_ready with dividend, divisor;
//        out_valid/out_ready with quotient, remainder, div_by_zero; busy = RUN or DONE.
module seq_divider16
  import seq_divider16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = div_cnt_w(WIDTH);

  div_state_t       state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q;     // dividend shifts out of the top while quotient bits enter below
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic             dbz;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic             accept;

  assign accept = in_valid && (state == IDLE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .q_msb    (q[WIDTH-1]),
    .dvsr     (dvsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:  if (count == CW'(1)) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Operand/result datapath; registers only change on accept or during RUN,
  // so the last result stays put through DONE and the following IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      q     <= '0;
      rem   <= '0;
      dvsr  <= '0;
      dbz   <= 1'b0;
    end else if (accept) begin
      if (divisor == '0) begin
        q   <= '1;
        rem <= dividend;
        dbz <= 1'b1;
      end else begin
        q     <= dividend;
        rem   <= '0;
        dvsr  <= divisor;
        dbz   <= 1'b0;
        count <= CW'(WIDTH);
      end
    end else if (state == RUN) begin
      q     <= {q[WIDTH-2:0], q_bit};
      rem   <= rem_next;
      count <= count - CW'(1);
    end
  end

  assign quotient    = q;
  assign remainder   = rem;
  assign div_by_zero = dbz;

endmodule
